rv_seq_ctrl: RTL and testbench

Parametrised instruction-sequencing controller for the multi-cycle RV32 core. Replaces the fixed wait-state top-level FSM with one that owns PC, instruction register and writeback sizing, and talks to memory through a req/ready handshake with a timeout. Adds single-step mode, a retired-instruction counter and latched fault codes. Sits between `instruction_decoder`/`ALU`/`register_file` and the memory port.

---
 rtl/rv_seq_ctrl_pkg.sv | 33 +++
 rtl/rv_seq_ctrl_load_extend.sv | 26 ++
 rtl/rv_seq_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_rv_seq_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_seq_ctrl_pkg.sv
// Shared types and constants for the RV32 instruction-sequencing controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rv_pkg;

    // Controller states; the encoding is exported on the 4-bit state port.
    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_FETCH = 4'd1,
        ST_EXEC  = 4'd2,
        ST_MEM   = 4'd3,
        ST_WB    = 4'd4,
        ST_PAUSE = 4'd5,
        ST_HALT  = 4'd6,
        ST_FAULT = 4'd7
    } state_t;

    // Latched fault causes.
    localparam logic [1:0] FAULT_NONE    = 2'd0;
    localparam logic [1:0] FAULT_DECODE  = 2'd1;
    localparam logic [1:0] FAULT_ALIGN   = 2'd2;
    localparam logic [1:0] FAULT_TIMEOUT = 2'd3;

    // Load sizing codes from the decoder (funct3 of the load).
    localparam logic [2:0] LS_SB = 3'd0;
    localparam logic [2:0] LS_SH = 3'd1;
    localparam logic [2:0] LS_UB = 3'd4;
    localparam logic [2:0] LS_UH = 3'd5;

    // Custom opcode that stops the sequencer.
    localparam logic [6:0] HALT_OPCODE = 7'h7F;

endpackage

// File: rtl/rv_seq_ctrl_load_extend.sv
// Sizes loaded data for writeback: sign/zero extension of byte and half loads.
// Latency: combinational.
// Backpressure: none.
module load_extend
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] din,
    input  logic [2:0]      size,
    output logic [XLEN-1:0] dout
);

    // Pick the extension by load size; word and unknown sizes pass through.
    always_comb begin
        dout = din;
        case (size)
            LS_SB:   dout = {{(XLEN-8){din[7]}},   din[7:0]};
            LS_SH:   dout = {{(XLEN-16){din[15]}}, din[15:0]};
            LS_UB:   dout = {{(XLEN-8){1'b0}},     din[7:0]};
            LS_UH:   dout = {{(XLEN-16){1'b0}},    din[15:0]};
            default: dout = din;
        endcase
    end

endmodule

// File: rtl/rv_seq_ctrl.sv
// Multi-cycle RV32 sequencer: owns PC, IR, writeback sizing, retire count and fault latch.
// Latency: ALU op 4 cycles (FETCH + 1 wait, EXEC, WB); loads/stores add MEM + 1 wait.
// Backpressure: mem_req held stable until mem_ready; no mem_ready within TIMEOUT cycles faults.
module rv_seq_ctrl
    import rv_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int TIMEOUT  = 15,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             step_mode,
    input  logic             step,
    output logic             mem_req,
    output logic [1:0]       mem_we,
    output logic [XLEN-1:0]  mem_addr,
    output logic [XLEN-1:0]  mem_wdata,
    input  logic [XLEN-1:0]  mem_rdata,
    input  logic             mem_ready,
    input  logic             mem_error,
    output logic [XLEN-1:0]  instr,
    input  logic             decode_error,
    input  logic             jump,
    input  logic             jal_or_jalr,
    input  logic             branch,
    input  logic             branch_taken,
    input  logic             mem_to_reg,
    input  logic             halt_op,
    input  logic [1:0]       mem_write_size,
    input  logic [2:0]       reg_load_size,
    input  logic [XLEN-1:0]  immediate,
    input  logic [XLEN-1:0]  rv1,
    input  logic [XLEN-1:0]  rv2,
    input  logic [XLEN-1:0]  alu_out,
    output logic             reg_we,
    output logic [XLEN-1:0]  reg_wdata,
    output logic [XLEN-1:0]  pc,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired,
    output logic             fault,
    output logic [1:0]       fault_code
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t          st;
    logic [TW-1:0]   wait_cnt;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] ext_data;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] next_pc;
    logic [XLEN-1:0] wb_data;
    logic            mem_done;
    logic            mem_tmo;

    assign state = st;

    load_extend #(.XLEN(XLEN)) u_load_extend (
        .din  (load_data),
        .size (reg_load_size),
        .dout (ext_data)
    );

    // Next PC, writeback source and request completion/timeout decode.
    always_comb begin
        pc_plus4 = pc + XLEN'(4);
        if (jump && jal_or_jalr)
            next_pc = pc + immediate;
        else if (jump)
            next_pc = (rv1 + immediate) & ~XLEN'(1);
        else if (branch && branch_taken)
            next_pc = pc + immediate;
        else
            next_pc = pc_plus4;

        if (jump)
            wb_data = pc_plus4;
        else if (mem_to_reg)
            wb_data = ext_data;
        else
            wb_data = alu_out;

        // The memory is registered: a ready in the request's first cycle is ignored.
        // Ready wins over an expiring timeout in the same cycle.
        mem_done = (wait_cnt != '0) && mem_ready;
        mem_tmo  = !mem_done && (wait_cnt == TW'(TIMEOUT - 1));
    end

    // Sequencer FSM with all memory/regfile outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            st         <= ST_IDLE;
            pc         <= RESET_PC;
            instr      <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 2'd0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            reg_we     <= 1'b0;
            reg_wdata  <= '0;
            retired    <= '0;
            fault      <= 1'b0;
            fault_code <= FAULT_NONE;
            wait_cnt   <= '0;
            load_data  <= '0;
        end else begin
            reg_we <= 1'b0;
            case (st)
                ST_IDLE: begin
                    if (run) begin
                        st       <= ST_FETCH;
                        mem_req  <= 1'b1;
                        mem_we   <= 2'd0;
                        mem_addr <= pc;
                        wait_cnt <= '0;
                    end
                end
                ST_FETCH, ST_MEM: begin
                    if (mem_done) begin
                        mem_req  <= 1'b0;
                        mem_we   <= 2'd0;
                        wait_cnt <= '0;
                        if (mem_error) begin
                            st         <= ST_FAULT;
                            fault      <= 1'b1;
                            fault_code <= FAULT_ALIGN;
                        end else if (st == ST_FETCH) begin
                            instr <= mem_rdata;
                            st    <= ST_EXEC;
                        end else begin
                            load_data <= mem_rdata;
                            st        <= ST_WB;
                        end
                    end else if (mem_tmo) begin
                        mem_req    <= 1'b0;
                        mem_we     <= 2'd0;
                        st         <= ST_FAULT;
                        fault      <= 1'b1;
                        fault_code <= FAULT_TIMEOUT;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end
                ST_EXEC: begin
                    if (halt_op) begin
                        st <= ST_HALT;
                    end else if (decode_error) begin
                        st         <= ST_FAULT;
                        fault      <= 1'b1;
                        fault_code <= FAULT_DECODE;
                    end else if (mem_to_reg || (mem_write_size != 2'd0)) begin
                        st        <= ST_MEM;
                        mem_req   <= 1'b1;
                        mem_addr  <= alu_out;
                        mem_we    <= mem_write_size;
                        mem_wdata <= rv2;
                        wait_cnt  <= '0;
                    end else begin
                        st <= ST_WB;
                    end
                end
                ST_WB: begin
                    reg_we    <= (mem_write_size == 2'd0);
                    reg_wdata <= wb_data;
                    retired   <= retired + CNT_W'(1);
                    pc        <= next_pc;
                    if (step_mode) begin
                        st <= ST_PAUSE;
                    end else begin
                        st       <= ST_FETCH;
                        mem_req  <= 1'b1;
                        mem_we   <= 2'd0;
                        mem_addr <= next_pc;
                        wait_cnt <= '0;
                    end
                end
                ST_PAUSE: begin
                    if (step || !step_mode) begin
                        st       <= ST_FETCH;
                        mem_req  <= 1'b1;
                        mem_we   <= 2'd0;
                        mem_addr <= pc;
                        wait_cnt <= '0;
                    end
                end
                ST_HALT, ST_FAULT: begin
                    st <= st;
                end
                default: begin
                    st <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv_seq_ctrl.sv
// Directed bench for rv_seq_ctrl: writebacks checked by a queue-based scoreboard.
// Latency: n/a.
// Backpressure: memory responses driven by the bench with programmable wait.
module tb_rv_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        run;
    logic        step_mode;
    logic        step;
    logic        mem_req;
    logic [1:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        mem_error;
    logic [31:0] instr;
    logic        decode_error, jump, jal_or_jalr, branch, branch_taken, mem_to_reg, halt_op;
    logic [1:0]  mem_write_size;
    logic [2:0]  reg_load_size;
    logic [31:0] immediate, rv1, rv2, alu_out;
    logic        reg_we;
    logic [31:0] reg_wdata;
    logic [31:0] pc;
    logic [3:0]  state;
    logic [31:0] retired;
    logic        fault;
    logic [1:0]  fault_code;

    typedef struct {
        logic [31:0] wdata;
        logic [31:0] pc;
        logic [31:0] ret;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   c0    = 0;

    rv_seq_ctrl dut (
        .clk(clk), .rst(rst), .run(run), .step_mode(step_mode), .step(step),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_error(mem_error),
        .instr(instr), .decode_error(decode_error), .jump(jump), .jal_or_jalr(jal_or_jalr),
        .branch(branch), .branch_taken(branch_taken), .mem_to_reg(mem_to_reg),
        .halt_op(halt_op), .mem_write_size(mem_write_size), .reg_load_size(reg_load_size),
        .immediate(immediate), .rv1(rv1), .rv2(rv2), .alu_out(alu_out),
        .reg_we(reg_we), .reg_wdata(reg_wdata), .pc(pc), .state(state),
        .retired(retired), .fault(fault), .fault_code(fault_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every register write strobe must match the oldest expected writeback.
    always @(negedge clk) begin
        if (reg_we) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_unexpected_we: got wdata 0x%08h, expected no write", reg_wdata);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("sb_wdata", reg_wdata, e.wdata);
                check("sb_pc", pc, e.pc);
                check("sb_retired", retired, e.ret);
            end
        end
    end

    task automatic push(input logic [31:0] w, input logic [31:0] p, input logic [31:0] r);
        exp_t e;
        e.wdata = w;
        e.pc    = p;
        e.ret   = r;
        q.push_back(e);
    endtask

    task automatic clear_inputs();
        run = 0; step_mode = 0; step = 0;
        mem_rdata = 0; mem_ready = 0; mem_error = 0;
        decode_error = 0; jump = 0; jal_or_jalr = 0; branch = 0; branch_taken = 0;
        mem_to_reg = 0; halt_op = 0; mem_write_size = 0; reg_load_size = 3'd2;
        immediate = 0; rv1 = 0; rv2 = 0; alu_out = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    // Raise run for exactly one edge; returns just after that edge.
    task automatic start();
        @(negedge clk);
        run = 1;
        c0 = cyc;
        @(posedge clk);
        #1 run = 0;
    endtask

    // Answer the next memory request after 'dly' extra cycles; returns one cycle after ready.
    task automatic serve(input string name, input logic [31:0] exp_addr,
                         input logic [31:0] data, input logic err, input int dly);
        bit seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_req) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL %s_req_timeout: got no mem_req, expected one", name);
        end else begin
            check({name, "_addr"}, mem_addr, exp_addr);
            repeat (dly) @(negedge clk);
            mem_rdata = data;
            mem_error = err;
            mem_ready = 1;
            @(negedge clk);
            mem_ready = 0;
            mem_error = 0;
        end
    endtask

    task automatic wait_we(input string name);
        bit seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (reg_we) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL %s_we_timeout: got no reg_we, expected one", name);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected end of run");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1;
        clear_inputs();

        // Reset values
        do_reset();
        check("rst_state", state, 32'd0);
        check("rst_pc", pc, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_mem_req", mem_req, 32'd0);
        check("rst_mem_we", mem_we, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_reg_we", reg_we, 32'd0);
        check("rst_reg_wdata", reg_wdata, 32'd0);
        check("rst_retired", retired, 32'd0);
        check("rst_fault", fault, 32'd0);
        check("rst_fault_code", fault_code, 32'd0);

        // ALU op: write strobe in the 5th cycle after run
        alu_out = 32'h0000_1234;
        push(32'h0000_1234, 32'd4, 32'd1);
        start();
        serve("alu_fetch", 32'd0, 32'h0000_0013, 0, 1);
        wait_we("alu");
        check("alu_latency", cyc - c0, 32'd5);
        check("alu_instr", instr, 32'h0000_0013);
        check("alu_next_fetch", mem_addr, 32'd4);

        // Loads: signed then unsigned byte
        do_reset();
        mem_to_reg = 1; reg_load_size = 3'd0; alu_out = 32'h200;
        push(32'hFFFF_FFF0, 32'd4, 32'd1);
        start();
        serve("lb_fetch", 32'd0, 32'h0000_0003, 0, 1);
        serve("lb_data", 32'h200, 32'h0000_00F0, 0, 1);
        wait_we("lb");
        reg_load_size = 3'd4;
        push(32'h0000_00F0, 32'd8, 32'd2);
        serve("lbu_fetch", 32'd4, 32'h0000_4003, 0, 1);
        serve("lbu_data", 32'h200, 32'h0000_00F0, 0, 1);
        wait_we("lbu");

        // JALR, JAL, taken branch
        do_reset();
        jump = 1; jal_or_jalr = 0; rv1 = 32'h103; immediate = 32'd4;
        push(32'd4, 32'h106, 32'd1);
        start();
        serve("jalr_fetch", 32'd0, 32'h0000_0067, 0, 1);
        wait_we("jalr");
        jal_or_jalr = 1; immediate = 32'h10;
        push(32'h10A, 32'h116, 32'd2);
        serve("jal_fetch", 32'h106, 32'h0000_006F, 0, 1);
        wait_we("jal");
        jump = 0; branch = 1; branch_taken = 1; immediate = 32'hFFFF_FFF8; alu_out = 32'h55;
        push(32'h55, 32'h10E, 32'd3);
        serve("br_fetch", 32'h116, 32'h0000_0063, 0, 1);
        wait_we("br");

        // Store: no register write, still retires
        do_reset();
        mem_write_size = 2'd2; rv2 = 32'hDEAD_BEEF; alu_out = 32'h300;
        start();
        serve("sw_fetch", 32'd0, 32'h0000_2023, 0, 1);
        serve("sw_data", 32'h300, 32'h0, 0, 1);
        @(negedge clk);
        check("sw_retired", retired, 32'd1);
        check("sw_pc", pc, 32'd4);
        check("sw_state", state, 32'd1);

        // Ready in the last allowed cycle counts as success
        do_reset();
        alu_out = 32'h77;
        push(32'h77, 32'd4, 32'd1);
        start();
        serve("late_fetch", 32'd0, 32'h0000_0013, 0, 14);
        check("late_state", state, 32'd2);
        check("late_fault", fault, 32'd0);
        wait_we("late");

        // Timeout after 15 waiting cycles
        do_reset();
        start();
        repeat (15) @(negedge clk);
        check("tmo_fault_before", fault, 32'd0);
        check("tmo_req_before", mem_req, 32'd1);
        @(negedge clk);
        check("tmo_fault", fault, 32'd1);
        check("tmo_code", fault_code, 32'd3);
        check("tmo_req_drop", mem_req, 32'd0);
        check("tmo_state", state, 32'd7);

        // Decode error faults and stays latched
        do_reset();
        decode_error = 1;
        start();
        serve("dec_fetch", 32'd0, 32'hFFFF_FFFF, 0, 1);
        @(negedge clk);
        check("dec_state", state, 32'd7);
        repeat (5) @(negedge clk);
        check("dec_code_sticky", fault_code, 32'd1);
        check("dec_req", mem_req, 32'd0);

        // Misaligned fetch
        do_reset();
        start();
        serve("align_fetch", 32'd0, 32'h0000_0013, 1, 1);
        check("align_state", state, 32'd7);
        check("align_code", fault_code, 32'd2);
        check("align_instr", instr, 32'd0);

        // Halt opcode
        do_reset();
        halt_op = 1;
        start();
        serve("halt_fetch", 32'd0, 32'h0000_007F, 0, 1);
        repeat (4) @(negedge clk);
        check("halt_state", state, 32'd6);
        check("halt_retired", retired, 32'd0);
        check("halt_req", mem_req, 32'd0);

        // Single-step
        do_reset();
        step_mode = 1; alu_out = 32'hABCD;
        push(32'hABCD, 32'd4, 32'd1);
        start();
        serve("step1_fetch", 32'd0, 32'h0000_0013, 0, 1);
        wait_we("step1");
        check("step1_state", state, 32'd5);
        repeat (4) @(negedge clk);
        check("step_hold_state", state, 32'd5);
        check("step_hold_req", mem_req, 32'd0);
        push(32'hABCD, 32'd8, 32'd2);
        @(negedge clk);
        step = 1;
        @(posedge clk);
        #1 step = 0;
        serve("step2_fetch", 32'd4, 32'h0000_0013, 0, 1);
        wait_we("step2");
        repeat (6) @(negedge clk);
        check("step2_state", state, 32'd5);
        check("step2_retired", retired, 32'd2);

        // Reset while a store waits in MEM
        do_reset();
        mem_write_size = 2'd3; rv2 = 32'h1234_5678; alu_out = 32'h400;
        start();
        serve("rst_fetch", 32'd0, 32'h0000_2023, 0, 1);
        @(negedge clk);
        check("rmem_state", state, 32'd3);
        check("rmem_we", mem_we, 32'd3);
        check("rmem_wdata", mem_wdata, 32'h1234_5678);
        rst = 1;
        mem_ready = 1;
        @(negedge clk);
        check("rmem_state_rst", state, 32'd0);
        check("rmem_req_rst", mem_req, 32'd0);
        check("rmem_we_rst", mem_we, 32'd0);
        check("rmem_addr_rst", mem_addr, 32'd0);
        check("rmem_wdata_rst", mem_wdata, 32'd0);
        check("rmem_pc_rst", pc, 32'd0);
        rst = 0;
        mem_ready = 0;
        repeat (3) @(negedge clk);
        check("rmem_retired", retired, 32'd0);
        check("rmem_idle", state, 32'd0);

        check("sb_drained", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
